// File: rtl/rx_pkt_assembler_if.sv
// Byte-stream input and wide-packet output handshakes of the RX packet assembler.
// The master side is the MAC feed plus downstream sink; the slave side is the assembler.
interface rx_pkt_assembler_if #(
  parameter int P_PKT_BITS = 1000*8
);
  logic                  in_byte_vld;
  logic                  in_byte_rdy;
  logic [7:0]            in_byte;
  logic                  in_byte_last;
  logic                  in_byte_err;
  logic                  rx_pkt_vld;
  logic                  rx_pkt_rdy;
  logic [P_PKT_BITS-1:0] rx_pkt;
  logic [9:0]            rx_pkt_bytes;

  modport master (
    output in_byte_vld, in_byte, in_byte_last, in_byte_err, rx_pkt_rdy,
    input  in_byte_rdy, rx_pkt_vld, rx_pkt, rx_pkt_bytes
  );

  modport slave (
    input  in_byte_vld, in_byte, in_byte_last, in_byte_err, rx_pkt_rdy,
    output in_byte_rdy, rx_pkt_vld, rx_pkt, rx_pkt_bytes
  );
endinterface

// File: rtl/rx_pkt_assembler.sv
// Packs a receive byte stream into one wide packet vector with a byte count;
// packets flagged bad or longer than the buffer are discarded and counted.
module rx_pkt_assembler #(
  parameter int P_PKT_BITS = 1000*8
) (
  input  logic                rx_clk,
  input  logic                rx_rst_n,
  rx_pkt_assembler_if.slave   bus,
  output logic                drop_pulse,
  output logic [15:0]         drop_cnt
);

  localparam int         P_MAX_BYTES = P_PKT_BITS / 8;
  localparam logic [9:0] MAX_BYTES   = 10'(P_MAX_BYTES);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DROP    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [P_PKT_BITS-1:0] pkt_q, pkt_d;
  logic [9:0]            bytes_q, bytes_d;
  logic                  vld_q, vld_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  byte_acc;
  logic                  drop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus.in_byte_rdy  = (state_q != S_PRESENT);
  assign byte_acc         = bus.in_byte_vld & bus.in_byte_rdy;
  assign bus.rx_pkt_vld   = vld_q;
  assign bus.rx_pkt       = pkt_q;
  assign bus.rx_pkt_bytes = bytes_q;
  assign drop_pulse       = drop_pulse_q;
  assign drop_cnt         = drop_cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pkt_d        = pkt_q;
    bytes_d      = bytes_q;
    vld_d        = vld_q;
    drop         = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (byte_acc) begin
          if (bus.in_byte_err || (cnt_q == MAX_BYTES)) begin
            // Clear the partial buffer so no residue leaks into the next packet.
            drop  = 1'b1;
            pkt_d = '0;
            cnt_d = '0;
            if (!bus.in_byte_last) state_d = S_DROP;
          end else begin
            pkt_d[{cnt_q, 3'b000} +: 8] = bus.in_byte;
            if (bus.in_byte_last) begin
              bytes_d = cnt_q + 10'd1;
              vld_d   = 1'b1;
              state_d = S_PRESENT;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
        end
      end
      S_DROP: begin
        if (byte_acc && bus.in_byte_last) begin
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_PRESENT: begin
        if (bus.rx_pkt_rdy) begin
          vld_d   = 1'b0;
          pkt_d   = '0;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    drop_pulse_d = drop;
    drop_cnt_d   = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q      <= S_COLLECT;
      cnt_q        <= '0;
      pkt_q        <= '0;
      bytes_q      <= '0;
      vld_q        <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pkt_q        <= pkt_d;
      bytes_q      <= bytes_d;
      vld_q        <= vld_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule
